// File: rtl/cpu_pkg.sv
// Shared RV32 core definitions: fetch FSM states and program counter constants.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EXEC,
        HALTED,
        FAULT
    } fetch_state_t;

    localparam int          PC_STEP          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts cycles spent waiting on instruction memory and flags when the
// response window has run out.
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Fires on the last permitted waiting cycle; the counter reaches TIMEOUT on that edge.
    assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch and PC sequencer: owns the PC, drives the
// instruction-memory request and holds the fetched word for decode.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC),
    parameter int                    TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] pc,
    input  logic                  PCsrc,
    input  logic [DATA_WIDTH-1:0] ImmOp,
    input  logic                  stall,
    input  logic                  halt,
    output logic                  fault
);

    fetch_state_t          state;
    logic [DATA_WIDTH-1:0] target;
    logic                  ctr_clear;
    logic                  ctr_enable;
    logic                  timeout_expired;

    assign ctr_clear  = (state == FETCH);
    assign ctr_enable = (state == WAIT);

    fetch_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (ctr_clear),
        .enable (ctr_enable),
        .expired(timeout_expired)
    );

    // Modulo-2^DATA_WIDTH add; wrap-around is intentional.
    assign target    = PCsrc ? (pc + ImmOp) : (pc + DATA_WIDTH'(PC_STEP));
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    imem_req <= 1'b1;
                    state    <= WAIT;
                end
                // An ack arriving on the expiry cycle still completes the fetch.
                WAIT: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= EXEC;
                    end else if (timeout_expired) begin
                        imem_req <= 1'b0;
                        fault    <= 1'b1;
                        state    <= FAULT;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        if (target[1:0] != 2'b00) begin
                            fault <= 1'b1;
                            state <= FAULT;
                        end else begin
                            pc    <= target;
                            state <= halt ? HALTED : FETCH;
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    fault       <= 1'b1;
                    state       <= FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized
// instruction stream checked against a PC-arithmetic reference model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic        PCsrc;
    logic [31:0] ImmOp;
    logic        stall;
    logic        halt;
    logic        fault;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    fetch_sequencer #(
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0),
        .TIMEOUT   (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .PCsrc      (PCsrc),
        .ImmOp      (ImmOp),
        .stall      (stall),
        .halt       (halt),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle_inputs();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        PCsrc      = 1'b0;
        ImmOp      = 32'h0;
        stall      = 1'b0;
        halt       = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called on a negedge; returns at the first negedge where a request is visible.
    task automatic wait_req(output logic seen, output int at_cyc);
        seen   = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            if (imem_req === 1'b1) begin
                seen   = 1'b1;
                at_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Drives one complete instruction (memory response, EXEC inputs) and reports observations.
    task automatic run_instr(input int ack_delay, input int stall_cyc, input logic src,
                             input logic [31:0] imm, input logic hlt, input logic [31:0] word,
                             output logic got_req, output int req_cyc,
                             output logic [31:0] addr_seen, output logic [31:0] instr_seen,
                             output int valid_cycles, output logic pc_held,
                             output logic [31:0] pc_after);
        logic [31:0] pc_before;
        addr_seen    = 32'hx;
        instr_seen   = 32'hx;
        valid_cycles = 0;
        pc_held      = 1'b1;
        pc_after     = 32'hx;
        wait_req(got_req, req_cyc);
        if (!got_req) return;
        addr_seen = imem_addr;
        repeat (ack_delay) @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        instr_seen = instr;
        pc_before  = pc;
        PCsrc      = src;
        ImmOp      = imm;
        halt       = hlt;
        for (int i = 0; i <= stall_cyc; i++) begin
            if (instr_valid === 1'b1) valid_cycles++;
            if (pc !== pc_before || instr !== instr_seen) pc_held = 1'b0;
            stall = (i < stall_cyc);
            @(negedge clk);
        end
        if (instr_valid === 1'b1) valid_cycles++;
        pc_after = pc;
        PCsrc    = 1'b0;
        ImmOp    = $urandom;
        halt     = 1'b0;
        stall    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        imem_ack = 1'b1;
        @(negedge clk);
        total++;
        if ({imem_req, instr_valid, fault} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_flags: got req/valid/fault=%b want 000", {imem_req, instr_valid, fault});
        end
        total++;
        if (pc !== 32'h0 || imem_addr !== 32'h0 || instr !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_regs: got pc=%h addr=%h instr=%h want 0/0/0", pc, imem_addr, instr);
        end
        imem_ack = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_req_edge1: got %b want 0", imem_req);
        end
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_req_edge2: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        logic got, held;
        int rc, prev_rc, vc;
        logic [31:0] a, ins, pa, word;
        prev_rc = 0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            word = $urandom;
            run_instr(0, 0, 1'b0, $urandom, 1'b0, word, got, rc, a, ins, vc, held, pa);
            total++;
            if (!got || a !== 32'(4 * k)) begin
                bad++;
                $display("[TB] FAIL seq_addr%0d: got req=%b addr=%h want req=1 addr=%h", k, got, a, 32'(4 * k));
            end
            total++;
            if (ins !== word) begin
                bad++;
                $display("[TB] FAIL seq_instr%0d: got %h want %h", k, ins, word);
            end
            if (k > 0) begin
                total++;
                if (rc - prev_rc != 3) begin
                    bad++;
                    $display("[TB] FAIL seq_cycles%0d: got %0d want 3", k, rc - prev_rc);
                end
            end
            prev_rc = rc;
        end
    endtask

    task automatic test_branch();
        logic got, held;
        int rc, vc;
        logic [31:0] a, ins, pa;
        do_reset();
        run_instr(0, 0, 1'b1, 32'h10, 1'b0, $urandom, got, rc, a, ins, vc, held, pa);
        run_instr(0, 0, 1'b1, 32'hFFFF_FFF8, 1'b0, $urandom, got, rc, a, ins, vc, held, pa);
        total++;
        if (a !== 32'h10 || pa !== 32'h08) begin
            bad++;
            $display("[TB] FAIL branch_taken: got addr=%h pc=%h want addr=10 pc=08", a, pa);
        end
        run_instr(0, 0, 1'b0, $urandom, 1'b0, $urandom, got, rc, a, ins, vc, held, pa);
        total++;
        if (a !== 32'h08) begin
            bad++;
            $display("[TB] FAIL branch_next_addr: got %h want 00000008", a);
        end
        do_reset();
        run_instr(0, 0, 1'b1, 32'h10, 1'b0, $urandom, got, rc, a, ins, vc, held, pa);
        run_instr(0, 0, 1'b0, 32'hFFFF_FFF8, 1'b0, $urandom, got, rc, a, ins, vc, held, pa);
        run_instr(0, 0, 1'b0, $urandom, 1'b0, $urandom, got, rc, a, ins, vc, held, pa);
        total++;
        if (a !== 32'h14) begin
            bad++;
            $display("[TB] FAIL branch_not_taken: got addr=%h want 00000014", a);
        end
    endtask

    task automatic test_stall();
        logic got, held;
        int rc, vc;
        logic [31:0] a, ins, pa;
        do_reset();
        run_instr(1, 4, 1'b0, $urandom, 1'b0, 32'hCAFE_0013, got, rc, a, ins, vc, held, pa);
        total++;
        if (vc != 5) begin
            bad++;
            $display("[TB] FAIL stall_valid_cycles: got %0d want 5", vc);
        end
        total++;
        if (!held || pa !== 32'h4) begin
            bad++;
            $display("[TB] FAIL stall_pc: got held=%b pc=%h want held=1 pc=00000004", held, pa);
        end
    endtask

    task automatic test_timeout();
        logic got;
        int rc, n;
        do_reset();
        wait_req(got, rc);
        n = 0;
        while (imem_req === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n != 15 || fault !== 1'b1 || imem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL timeout_fault: got wait=%0d fault=%b req=%b want 15/1/0", n, fault, imem_req);
        end
        imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        imem_ack = 1'b0;
        total++;
        if (fault !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL timeout_sticky: got fault=%b valid=%b req=%b want 1/0/0", fault, instr_valid, imem_req);
        end
        do_reset();
        wait_req(got, rc);
        repeat (14) @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_ack = 1'b0;
        total++;
        if (instr_valid !== 1'b1 || fault !== 1'b0 || instr !== 32'h1234_5678) begin
            bad++;
            $display("[TB] FAIL timeout_late_ack: got valid=%b fault=%b instr=%h want 1/0/12345678", instr_valid, fault, instr);
        end
    endtask

    task automatic test_misaligned_and_wrap();
        logic got, held;
        int rc, vc;
        logic [31:0] a, ins, pa;
        do_reset();
        run_instr(0, 0, 1'b1, 32'h20, 1'b0, $urandom, got, rc, a, ins, vc, held, pa);
        run_instr(0, 0, 1'b1, 32'h2, 1'b0, $urandom, got, rc, a, ins, vc, held, pa);
        repeat (3) @(negedge clk);
        total++;
        if (a !== 32'h20 || pc !== 32'h20 || fault !== 1'b1 || imem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL misaligned: got addr=%h pc=%h fault=%b req=%b want 20/20/1/0", a, pc, fault, imem_req);
        end
        do_reset();
        run_instr(0, 0, 1'b1, 32'hFFFF_FFFC, 1'b0, $urandom, got, rc, a, ins, vc, held, pa);
        run_instr(0, 0, 1'b0, $urandom, 1'b0, $urandom, got, rc, a, ins, vc, held, pa);
        total++;
        if (a !== 32'hFFFF_FFFC || pa !== 32'h0 || fault !== 1'b0) begin
            bad++;
            $display("[TB] FAIL pc_wrap: got addr=%h pc=%h fault=%b want fffffffc/0/0", a, pa, fault);
        end
    endtask

    task automatic test_halt();
        logic got, held, saw_req;
        int rc, vc;
        logic [31:0] a, ins, pa;
        do_reset();
        run_instr(0, 0, 1'b0, $urandom, 1'b1, $urandom, got, rc, a, ins, vc, held, pa);
        saw_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            imem_ack = (i % 2 == 0);
            if (imem_req !== 1'b0 || instr_valid !== 1'b0) saw_req = 1'b1;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        total++;
        if (pa !== 32'h4 || pc !== 32'h4 || saw_req) begin
            bad++;
            $display("[TB] FAIL halt: got pc=%h/%h activity=%b want 4/4/0", pa, pc, saw_req);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic got, held;
        int rc, vc;
        logic [31:0] a, ins, pa;
        do_reset();
        run_instr(0, 0, 1'b0, $urandom, 1'b0, 32'h0BAD_F00D, got, rc, a, ins, vc, held, pa);
        wait_req(got, rc);
        rst_n = 1'b0;
        #1;
        total++;
        if (pc !== 32'h0 || imem_req !== 1'b0 || instr !== 32'h0) begin
            bad++;
            $display("[TB] FAIL async_reset: got pc=%h req=%b instr=%h want 0/0/0", pc, imem_req, instr);
        end
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        rst_n      = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || instr !== 32'h0) begin
            bad++;
            $display("[TB] FAIL stale_ack: got valid=%b instr=%h want 0/0", instr_valid, instr);
        end
        wait_req(got, rc);
        total++;
        if (!got || imem_addr !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_refetch: got req=%b addr=%h want 1/0", got, imem_addr);
        end
    endtask

    // Reference model: the PC is plain modulo-2^32 arithmetic per committed instruction.
    task automatic test_random();
        logic got, held, src, hlt;
        int rc, vc, dly, stl, r;
        logic [31:0] a, ins, pa, imm, word, pc_model;
        int n_instr;
        n_instr  = 25;
        pc_model = 32'h0;
        do_reset();
        for (int k = 0; k < n_instr; k++) begin
            dly  = int'($urandom_range(0, 4));
            stl  = int'($urandom_range(0, 3));
            src  = 1'($urandom_range(0, 1));
            r    = int'($urandom_range(0, 63)) - 32;
            imm  = 32'(r * 4);
            word = $urandom;
            hlt  = (k == n_instr - 1);
            run_instr(dly, stl, src, imm, hlt, word, got, rc, a, ins, vc, held, pa);
            total++;
            if (!got || a !== pc_model || ins !== word) begin
                bad++;
                $display("[TB] FAIL rand_fetch%0d: got req=%b addr=%h instr=%h want 1/%h/%h", k, got, a, ins, pc_model, word);
            end
            pc_model = src ? pc_model + imm : pc_model + 32'd4;
            total++;
            if (vc != stl + 1 || !held || pa !== pc_model) begin
                bad++;
                $display("[TB] FAIL rand_exec%0d: got valid=%0d held=%b pc=%h want %0d/1/%h", k, vc, held, pa, stl + 1, pc_model);
            end
        end
        repeat (4) @(negedge clk);
        total++;
        if (imem_req !== 1'b0 || pc !== pc_model || fault !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rand_halted: got req=%b pc=%h fault=%b want 0/%h/0", imem_req, pc, fault, pc_model);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_timeout();
        test_misaligned_and_wrap();
        test_halt();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
